ecc_sed_checker: RTL and testbench

Single-error-detect (SED) checker for the 13-bit even-parity codewords produced by `ecc_sed_encoder`; it sits directly downstream of that encoder on the same clock. Each accepted codeword is checked by recomputing the parity over all 13 bits. The block then forwards the 12-bit payload through a registered valid/ready output stage with a per-word error flag. It also keeps a saturating error count and a sticky burst-error alarm for the status block.

---
 rtl/ecc_sed_pkg.sv | 19 +
 rtl/ecc_sed_stats.sv | 71 +++++++
 rtl/ecc_sed_checker.sv | 64 ++++++
 tb/tb_ecc_sed_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the 13-bit even-parity SED encoder/checker pair.
package ecc_sed_pkg;

    localparam int unsigned DATA_W = 12;

    typedef logic [DATA_W:0] codeword_t;

    typedef enum logic [1:0] {
        StNormal  = 2'd0,
        StSuspect = 2'd1,
        StAlarm   = 2'd2
    } sed_state_e;

    // 1 means an odd number of bits flipped somewhere in the codeword.
    function automatic logic sed_syndrome(input codeword_t cw);
        return ^cw;
    endfunction

endpackage

// File: rtl/ecc_sed_stats.sv
// Error statistics: saturating error counter, saturating run counter and sticky burst alarm FSM.
module ecc_sed_stats
    import ecc_sed_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ALARM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accept,
    input  logic             i_syndrome,
    input  logic             i_clr_stats,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_alarm
);

    localparam logic [7:0] RUN_THRESH = 8'(ALARM_THRESH);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       r_run;
    logic [7:0]       w_run_next;
    logic [7:0]       w_run_inc;
    sed_state_e       r_state;
    sed_state_e       w_state_next;

    assign w_run_inc = (r_run == 8'hFF) ? r_run : r_run + 8'd1;

    always_comb begin
        w_cnt_next   = r_cnt;
        w_run_next   = r_run;
        w_state_next = r_state;
        if (i_clr_stats) begin
            w_cnt_next   = '0;
            w_run_next   = '0;
            w_state_next = StNormal;
        end else if (i_accept) begin
            if (i_syndrome) begin
                if (r_cnt != '1) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
                w_run_next = w_run_inc;
                if (r_state != StAlarm) begin
                    w_state_next = (w_run_inc >= RUN_THRESH) ? StAlarm : StSuspect;
                end
            end else begin
                // A clean word ends the burst, but ALARM is sticky until cleared.
                w_run_next = '0;
                if (r_state != StAlarm) begin
                    w_state_next = StNormal;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_run   <= '0;
            r_state <= StNormal;
        end else begin
            r_cnt   <= w_cnt_next;
            r_run   <= w_run_next;
            r_state <= w_state_next;
        end
    end

    assign o_err_count = r_cnt;
    assign o_alarm     = (r_state == StAlarm);

endmodule

// File: rtl/ecc_sed_checker.sv
// SED checker: parity-checks each accepted codeword and forwards the payload through a
// registered valid/ready stage with a per-word error flag and error statistics.
module ecc_sed_checker #(
    parameter int unsigned DATA_W       = ecc_sed_pkg::DATA_W,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ALARM_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    input  logic [DATA_W:0]   enc_codeword,
    output logic              in_ready,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_err,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  err_count,
    output logic              alarm
);

    logic              r_dec_valid;
    logic [DATA_W-1:0] r_dec_data;
    logic              r_dec_err;
    logic              w_accept;
    logic              w_syndrome;

    assign in_ready   = !r_dec_valid || dec_ready;
    assign w_accept   = enc_valid && in_ready;
    assign w_syndrome = ^enc_codeword;

    // An accept in the same cycle as an output handshake replaces the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec_data  <= '0;
            r_dec_err   <= 1'b0;
        end else if (w_accept) begin
            r_dec_valid <= 1'b1;
            r_dec_data  <= enc_codeword[DATA_W-1:0];
            r_dec_err   <= w_syndrome;
        end else if (dec_ready) begin
            r_dec_valid <= 1'b0;
        end
    end

    assign dec_valid = r_dec_valid;
    assign dec_data  = r_dec_data;
    assign dec_err   = r_dec_err;

    ecc_sed_stats #(
        .CNT_W        (CNT_W),
        .ALARM_THRESH (ALARM_THRESH)
    ) u_stats (
        .clk         (clk),
        .rst         (rst),
        .i_accept    (w_accept),
        .i_syndrome  (w_syndrome),
        .i_clr_stats (clr_stats),
        .o_err_count (err_count),
        .o_alarm     (alarm)
    );

endmodule

// File: tb/tb_ecc_sed_checker.sv
// Self-checking bench: directed literal checks plus randomized traffic against a behavioural model.
module tb_ecc_sed_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_valid;
    logic [12:0] enc_codeword;
    logic        in_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic [11:0] dec_data;
    logic        dec_err;
    logic        clr_stats;
    logic [15:0] err_count;
    logic        alarm;

    logic        in_ready4;
    logic        dec_valid4;
    logic [11:0] dec_data4;
    logic        dec_err4;
    logic [3:0]  err_count4;
    logic        alarm4;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    bit       m_valid = 0;
    bit [11:0] m_data = 0;
    bit       m_err   = 0;
    int       m_cnt   = 0;
    int       m_cnt4  = 0;
    int       m_run   = 0;
    bit       m_alarm = 0;

    always #5 clk = ~clk;

    ecc_sed_checker dut (
        .clk          (clk),
        .rst          (rst),
        .enc_valid    (enc_valid),
        .enc_codeword (enc_codeword),
        .in_ready     (in_ready),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_data     (dec_data),
        .dec_err      (dec_err),
        .clr_stats    (clr_stats),
        .err_count    (err_count),
        .alarm        (alarm)
    );

    ecc_sed_checker #(
        .CNT_W (4)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .enc_valid    (enc_valid),
        .enc_codeword (enc_codeword),
        .in_ready     (in_ready4),
        .dec_valid    (dec_valid4),
        .dec_ready    (dec_ready),
        .dec_data     (dec_data4),
        .dec_err      (dec_err4),
        .clr_stats    (clr_stats),
        .err_count    (err_count4),
        .alarm        (alarm4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: next state derived directly from the handshake and parity rules.
    always @(posedge clk) begin
        bit acc;
        bit syn;
        acc = enc_valid && (!m_valid || dec_ready);
        syn = ($countones(enc_codeword) % 2) == 1;
        if (rst) begin
            m_valid <= 0; m_data <= 0; m_err <= 0;
            m_cnt <= 0; m_cnt4 <= 0; m_run <= 0; m_alarm <= 0;
        end else begin
            if (acc) begin
                m_valid <= 1;
                m_data  <= enc_codeword[11:0];
                m_err   <= syn;
            end else if (dec_ready) begin
                m_valid <= 0;
            end
            if (clr_stats) begin
                m_cnt <= 0; m_cnt4 <= 0; m_run <= 0; m_alarm <= 0;
            end else if (acc) begin
                if (syn) begin
                    m_cnt  <= (m_cnt  < 65535) ? m_cnt + 1  : 65535;
                    m_cnt4 <= (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
                    m_run  <= (m_run  < 255)   ? m_run + 1  : 255;
                    if (m_run + 1 >= 4) m_alarm <= 1;
                end else begin
                    m_run <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dec_valid", 32'(dec_valid), 32'(m_valid));
            chk("dec_data", 32'(dec_data), 32'(m_data));
            chk("dec_err", 32'(dec_err), 32'(m_err));
            chk("in_ready", 32'(in_ready), 32'(!m_valid || dec_ready));
            chk("err_count", 32'(err_count), 32'(m_cnt));
            chk("alarm", 32'(alarm), 32'(m_alarm));
            chk("dec_valid4", 32'(dec_valid4), 32'(m_valid));
            chk("err_count4", 32'(err_count4), 32'(m_cnt4));
            chk("alarm4", 32'(alarm4), 32'(m_alarm));
        end
    end

    task automatic step(input logic r, input logic v, input logic [12:0] cw,
                        input logic rdy, input logic c);
        rst = r; enc_valid = v; enc_codeword = cw; dec_ready = rdy; clr_stats = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 0, 13'h0, 1, 0);
        chk_en = 1'b1;
        step(1, 0, 13'h0, 1, 0);
        chk("rst_valid", 32'(dec_valid), 0);
        chk("rst_data", 32'(dec_data), 0);
        chk("rst_cnt", 32'(err_count), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        step(0, 1, 13'h1ABC, 1, 0);
        chk("clean_valid", 32'(dec_valid), 1);
        chk("clean_data", 32'(dec_data), 32'h0ABC);
        chk("clean_err", 32'(dec_err), 0);
        chk("clean_cnt", 32'(err_count), 0);
        step(0, 1, 13'h0ABC, 1, 0);
        chk("par_flip_err", 32'(dec_err), 1);
        step(0, 1, 13'h1ABD, 1, 0);
        chk("data_flip_err", 32'(dec_err), 1);
        chk("two_err_cnt", 32'(err_count), 2);
        step(0, 1, 13'h1ABF, 1, 0);
        chk("double_flip_err", 32'(dec_err), 0);

        step(0, 1, 13'h1001, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 13'h1002, 0, 0);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_hold_data", 32'(dec_data), 32'h001);
        end
        step(0, 1, 13'h1002, 1, 0);
        chk("bp_release_data", 32'(dec_data), 32'h002);
        step(0, 1, 13'h1003, 1, 0);
        chk("bp_next_data", 32'(dec_data), 32'h003);

        step(0, 1, 13'h1001, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 13'h0001, 1, 0);
            chk("burst_alarm", 32'(alarm), (i == 3) ? 1 : 0);
        end
        chk("burst_cnt", 32'(err_count), 7);
        step(0, 1, 13'h1001, 1, 0);
        chk("alarm_sticky", 32'(alarm), 1);
        step(0, 0, 13'h0, 1, 1);
        chk("clr_alarm", 32'(alarm), 0);
        chk("clr_cnt", 32'(err_count), 0);

        step(0, 1, 13'h0001, 1, 0);
        step(0, 1, 13'h0001, 1, 0);
        step(0, 1, 13'h1001, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 13'h0001, 1, 0);
        chk("broken_run_alarm", 32'(alarm), 0);
        chk("broken_run_cnt", 32'(err_count), 5);

        step(0, 1, 13'h0001, 1, 1);
        chk("clr_coinc_err", 32'(dec_err), 1);
        chk("clr_coinc_cnt", 32'(err_count), 0);

        for (int i = 0; i < 17; i++) step(0, 1, 13'h0001, 1, 0);
        chk("sat_cnt4", 32'(err_count4), 15);
        chk("sat_cnt16", 32'(err_count), 17);

        step(0, 1, 13'h0005, 0, 0);
        chk("pre_rst_valid", 32'(dec_valid), 1);
        step(1, 0, 13'h0, 0, 0);
        chk("mid_rst_valid", 32'(dec_valid), 0);
        chk("mid_rst_data", 32'(dec_data), 0);
        chk("mid_rst_err", 32'(dec_err), 0);
        chk("mid_rst_cnt", 32'(err_count), 0);
        chk("mid_rst_alarm", 32'(alarm), 0);

        for (int i = 0; i < 3000; i++) begin
            logic [12:0] cw;
            cw = 13'($urandom_range(0, 8191));
            // Bias toward error bursts so the alarm path is exercised.
            if ($urandom_range(0, 3) == 0) cw = {~(^cw[11:0]), cw[11:0]};
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), cw,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        step(0, 0, 13'h0, 1, 0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
